spi_word_assembler: RTL and testbench
=====================================

SPI_WORD_ASSEMBLER -- requirements
Module: spi_word_assembler

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 12, meaning the number of 32-bit words accepted per frame (range 1..16).
REQ-002 SHALL have port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port cs_n, input, 1 bit: frame select, already synchronised to clk; low means frame active.
REQ-005 SHALL have port byte_in, input, 8 bits: received byte, taken from the upstream shift register's parallel output.
REQ-006 SHALL have port byte_valid, input, 1 bit: one-cycle pulse meaning byte_in is complete.
REQ-007 SHALL have port tx_byte, output, 8 bits: byte to be preloaded into the upstream shift register.
REQ-008 SHALL have port tx_load, output, 1 bit: one-cycle pulse telling the shift register to parallel-load tx_byte.
REQ-009 SHALL have port word_out, output, 32 bits: assembled word, MSB byte first.
REQ-010 SHALL have port word_addr, output, 4 bits: word index within the frame.
REQ-011 SHALL have port word_valid, output, 1 bit: word_out/word_addr are valid.
REQ-012 SHALL have port word_ready, input, 1 bit: consumer accepts the word when word_valid and word_ready are both high.
REQ-013 SHALL have port status, output, 8 bits: {overrun, chk_err, frame_err, 1'b0, words_accepted[3:0]}.

Function
REQ-014 SHALL implement states IDLE, CMD, DATA, DISCARD.
REQ-015 SHALL, in IDLE, on a cs_n high-to-low transition, drive tx_byte=status and pulse tx_load for exactly 1 cycle, then enter CMD.
REQ-016 SHALL, in CMD, treat the first byte_valid as the command: {7'b1010101, clr}; a match enters DATA with word_addr=0, and clr=1 also clears overrun, chk_err and frame_err in that cycle.
REQ-017 SHALL, in CMD, on a command mismatch, set frame_err and enter DISCARD.
REQ-018 SHALL, in DATA, shift each byte into a 32-bit accumulator MSB first; the 4th byte completes a word.
REQ-019 SHALL, on word completion, load word_out and word_addr and raise word_valid in the next cycle (latency 1 clk from byte_valid).
REQ-020 SHALL hold word_valid, word_out and word_addr stable until accepted; on acceptance, drop word_valid next cycle unless a new word loads in that same cycle, increment words_accepted (saturating at 15), and increment word_addr.
REQ-021 SHALL keep accepting bytes while word_valid is pending; if a word completes while the previous word is unaccepted, it SHALL set overrun (sticky), drop the new word, keep the pending word, and enter DISCARD.
REQ-022 SHALL, when word_addr reaches MAX_WORDS after acceptance, treat further bytes as an error: set frame_err and enter DISCARD.
REQ-023 SHALL, one cycle after every byte_valid in CMD or DATA, drive tx_byte=byte_in (echo) and pulse tx_load.
REQ-024 SHALL, in DISCARD, ignore bytes and drive no tx_load.
REQ-025 SHALL, on cs_n rising in any state, return to IDLE and discard a partial word; a pending word_valid SHALL remain until accepted.
REQ-026 SHALL ignore a byte_valid coinciding with cs_n rising.

Reset
REQ-027 SHALL, while reset is high, force state=IDLE, word_valid=0, tx_load=0, tx_byte=0, word_out=0, word_addr=0, status=0, and clear the accumulator and byte counter.
REQ-028 SHALL give reset priority over all other inputs; reset mid-frame leaves the block in IDLE and requires a new cs_n falling edge.

Configuration
REQ-029 SHALL, when SPI_ASM_CHECKSUM_EN is defined, expect a 5th byte per word equal to the XOR of the 4 data bytes; on a match the word is emitted, on a mismatch chk_err is set, the word is dropped, and word_addr is unchanged.
REQ-030 SHALL, when SPI_ASM_CHECKSUM_EN is undefined, use 4-byte words, tie chk_err to 0, and omit all checksum logic.

Verification
REQ-031 SHALL cover: cs_n fall after reset -> tx_load pulse with tx_byte=8'h00.
REQ-032 SHALL cover: cmd 8'hAA, bytes DE AD BE EF, word_ready=1 -> word_out=32'hDEADBEEF, addr 0, status[3:0]=1.
REQ-033 SHALL cover: word_ready=0 while 8 data bytes arrive -> first word held, overrun=1, state DISCARD, second word never emitted.
REQ-034 SHALL cover: cmd 8'h12 -> frame_err=1, no word_valid; next frame with cmd 8'hAB -> frame_err cleared.
REQ-035 SHALL cover: cs_n rises after 2 data bytes -> no word; next frame's first word has addr 0.
REQ-036 SHALL cover (checksum build only): bytes 01 02 03 04 checksum 05 -> chk_err=1, no word; the same bytes with checksum 04 -> word 32'h01020304 emitted.

Source files
------------

// File: rtl/spi_word_assembler.sv
// spi_word_assembler: SPI frame decoder that turns a command byte plus data bytes into 32-bit words.
// Define SPI_ASM_CHECKSUM_EN to require a 5th XOR checksum byte after each word.
module spi_word_assembler #(
   parameter int MAX_WORDS = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs_n,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic [7:0]  tx_byte,
   output logic        tx_load,
   output logic [31:0] word_out,
   output logic [3:0]  word_addr,
   output logic        word_valid,
   input  logic        word_ready,
   output logic [7:0]  status
);

   typedef enum logic [1:0] {IDLE, CMD, DATA, DISCARD} state_e;

`ifdef SPI_ASM_CHECKSUM_EN
   localparam logic [2:0] LAST_BYTE = 3'd4;
`else
   localparam logic [2:0] LAST_BYTE = 3'd3;
`endif
   localparam logic [4:0] MAX_W = 5'(MAX_WORDS);

   state_e      state_q, state_d;
   logic        cs_q;
   logic [31:0] acc_q, acc_d;
   logic [2:0]  bcnt_q, bcnt_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [3:0]  wacc_q, wacc_d;
   logic        ovr_q, ovr_d;
   logic        ferr_q, ferr_d;
   logic        chk_err;
   logic [31:0] word_out_q, word_out_d;
   logic [3:0]  word_addr_q, word_addr_d;
   logic        word_valid_q, word_valid_d;
   logic [7:0]  tx_byte_q, tx_byte_d;
   logic        tx_load_q, tx_load_d;

`ifdef SPI_ASM_CHECKSUM_EN
   logic        chk_q, chk_d;
   logic [7:0]  xor_q, xor_d;
   assign chk_err = chk_q;
`else
   assign chk_err = 1'b0;
`endif

   logic        cs_fall, cs_rise, bv, accept, done;
   logic [4:0]  idx;
   logic [31:0] done_word;

   assign cs_fall = cs_q & ~cs_n;
   assign cs_rise = ~cs_q & cs_n;
   assign bv      = byte_valid & ~cs_rise;
   assign accept  = word_valid_q & word_ready;
   // index the next completed word would take, counting an acceptance this cycle
   assign idx     = cnt_q + {4'd0, accept};

   assign status     = {ovr_q, chk_err, ferr_q, 1'b0, wacc_q};
   assign tx_byte    = tx_byte_q;
   assign tx_load    = tx_load_q;
   assign word_out   = word_out_q;
   assign word_addr  = word_addr_q;
   assign word_valid = word_valid_q;

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      bcnt_d       = bcnt_q;
      cnt_d        = cnt_q;
      wacc_d       = wacc_q;
      ovr_d        = ovr_q;
      ferr_d       = ferr_q;
      word_out_d   = word_out_q;
      word_addr_d  = word_addr_q;
      word_valid_d = word_valid_q;
      tx_byte_d    = tx_byte_q;
      tx_load_d    = 1'b0;
      done         = 1'b0;
      done_word    = 32'd0;
`ifdef SPI_ASM_CHECKSUM_EN
      chk_d        = chk_q;
      xor_d        = xor_q;
`endif

      if (accept) begin
         word_valid_d = 1'b0;
         word_addr_d  = word_addr_q + 4'd1;
         cnt_d        = cnt_q + 5'd1;
         if (wacc_q != 4'hF) wacc_d = wacc_q + 4'd1;
      end

      if (cs_rise) begin
         state_d = IDLE;
         acc_d   = 32'd0;
         bcnt_d  = 3'd0;
`ifdef SPI_ASM_CHECKSUM_EN
         xor_d   = 8'h00;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  tx_byte_d = status;
                  tx_load_d = 1'b1;
                  state_d   = CMD;
               end
            end
            CMD: begin
               if (bv) begin
                  tx_byte_d = byte_in;
                  tx_load_d = 1'b1;
                  if (byte_in[7:1] == 7'b1010101) begin
                     state_d = DATA;
                     cnt_d   = 5'd0;
                     acc_d   = 32'd0;
                     bcnt_d  = 3'd0;
                     if (!word_valid_q || accept) word_addr_d = 4'd0;
                     if (byte_in[0]) begin
                        ovr_d  = 1'b0;
                        ferr_d = 1'b0;
`ifdef SPI_ASM_CHECKSUM_EN
                        chk_d  = 1'b0;
`endif
                     end
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = DISCARD;
                  end
               end
            end
            DATA: begin
               if (bv) begin
                  tx_byte_d = byte_in;
                  tx_load_d = 1'b1;
                  if (idx >= MAX_W) begin
                     ferr_d  = 1'b1;
                     state_d = DISCARD;
                  end else begin
`ifdef SPI_ASM_CHECKSUM_EN
                     if (bcnt_q == LAST_BYTE) begin
                        bcnt_d = 3'd0;
                        xor_d  = 8'h00;
                        if (byte_in == xor_q) begin
                           done      = 1'b1;
                           done_word = acc_q;
                        end else begin
                           chk_d = 1'b1;
                        end
                     end else begin
                        acc_d  = (acc_q << 8) | {24'd0, byte_in};
                        xor_d  = xor_q ^ byte_in;
                        bcnt_d = bcnt_q + 3'd1;
                     end
`else
                     acc_d = (acc_q << 8) | {24'd0, byte_in};
                     if (bcnt_q == LAST_BYTE) begin
                        bcnt_d    = 3'd0;
                        done      = 1'b1;
                        done_word = acc_d;
                     end else begin
                        bcnt_d = bcnt_q + 3'd1;
                     end
`endif
                  end
               end
            end
            DISCARD: begin
            end
            default: state_d = IDLE;
         endcase
      end

      // a word finishing on top of an unaccepted one is dropped
      if (done) begin
         if (word_valid_q && !accept) begin
            ovr_d   = 1'b1;
            state_d = DISCARD;
         end else begin
            word_out_d   = done_word;
            word_addr_d  = idx[3:0];
            word_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cs_q         <= 1'b0;
         acc_q        <= 32'd0;
         bcnt_q       <= 3'd0;
         cnt_q        <= 5'd0;
         wacc_q       <= 4'd0;
         ovr_q        <= 1'b0;
         ferr_q       <= 1'b0;
         word_out_q   <= 32'd0;
         word_addr_q  <= 4'd0;
         word_valid_q <= 1'b0;
         tx_byte_q    <= 8'h00;
         tx_load_q    <= 1'b0;
`ifdef SPI_ASM_CHECKSUM_EN
         chk_q        <= 1'b0;
         xor_q        <= 8'h00;
`endif
      end else begin
         state_q      <= state_d;
         cs_q         <= cs_n;
         acc_q        <= acc_d;
         bcnt_q       <= bcnt_d;
         cnt_q        <= cnt_d;
         wacc_q       <= wacc_d;
         ovr_q        <= ovr_d;
         ferr_q       <= ferr_d;
         word_out_q   <= word_out_d;
         word_addr_q  <= word_addr_d;
         word_valid_q <= word_valid_d;
         tx_byte_q    <= tx_byte_d;
         tx_load_q    <= tx_load_d;
`ifdef SPI_ASM_CHECKSUM_EN
         chk_q        <= chk_d;
         xor_q        <= xor_d;
`endif
      end
   end

endmodule

// File: tb/tb_spi_word_assembler.sv
// tb_spi_word_assembler: directed and random frames checked against a frame-level model.
// Build with SPI_ASM_CHECKSUM_EN defined to exercise the checksum byte.
`timescale 1ns/1ps
module tb_spi_word_assembler;
   localparam int MAXW = 12;
`ifdef SPI_ASM_CHECKSUM_EN
   localparam int BPW = 5;
`else
   localparam int BPW = 4;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cs_n = 1'b1;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        word_ready = 1'b1;
   logic [7:0]  tx_byte;
   logic        tx_load;
   logic [31:0] word_out;
   logic [3:0]  word_addr;
   logic        word_valid;
   logic [7:0]  status;

   spi_word_assembler #(.MAX_WORDS(MAXW)) dut (
      .clk(clk), .reset(reset), .cs_n(cs_n),
      .byte_in(byte_in), .byte_valid(byte_valid),
      .tx_byte(tx_byte), .tx_load(tx_load),
      .word_out(word_out), .word_addr(word_addr),
      .word_valid(word_valid), .word_ready(word_ready),
      .status(status)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [7:0]  stim[$];
   logic [7:0]  exp_tx[$];
   logic [7:0]  got_tx[$];
   logic [35:0] exp_w[$];
   logic [35:0] got_w[$];
   logic        m_ovr = 1'b0;
   logic        m_chk = 1'b0;
   logic        m_ferr = 1'b0;
   logic [3:0]  m_wacc = 4'd0;
   logic        pv = 1'b0;
   logic        pr = 1'b0;
   logic [35:0] pw = 36'd0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] m_status();
      return {m_ovr, m_chk, m_ferr, 1'b0, m_wacc};
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         if (pv && !pr) begin
            check("hold_valid", 64'(word_valid), 64'd1);
            check("hold_word", 64'({word_addr, word_out}), 64'(pw));
         end
         if (word_valid && word_ready) got_w.push_back({word_addr, word_out});
         if (tx_load) got_tx.push_back(tx_byte);
      end
      pv = word_valid;
      pr = word_ready;
      pw = {word_addr, word_out};
   end

   initial begin
      #5ms;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      byte_in = b;
      byte_valid = 1'b1;
      tick(1);
      byte_valid = 1'b0;
      tick(2);
   endtask

   task automatic start_frame();
      got_tx.delete();
      cs_n = 1'b0;
      tick(3);
   endtask

   task automatic end_frame();
      tick(3);
      cs_n = 1'b1;
      tick(4);
   endtask

   task automatic gen_words(input int nw);
      logic [7:0] b[4];
      for (int w = 0; w < nw; w++) begin
         for (int j = 0; j < 4; j++) begin
            b[j] = 8'($urandom);
            stim.push_back(b[j]);
         end
         if (BPW == 5) stim.push_back(b[0] ^ b[1] ^ b[2] ^ b[3]);
      end
   endtask

   // frame-level expectation with word_ready held high throughout
   task automatic model_frame(input logic [7:0] cmd);
      int k;
      logic [7:0] g[$];
      logic [7:0] x;
      exp_tx.push_back(m_status());
      exp_tx.push_back(cmd);
      if (cmd[7:1] != 7'h55) begin
         m_ferr = 1'b1;
         return;
      end
      if (cmd[0]) begin
         m_ovr = 1'b0;
         m_chk = 1'b0;
         m_ferr = 1'b0;
      end
      k = 0;
      foreach (stim[i]) begin
         exp_tx.push_back(stim[i]);
         if (k == MAXW) begin
            m_ferr = 1'b1;
            break;
         end
         g.push_back(stim[i]);
         if (g.size() == BPW) begin
            x = g[0] ^ g[1] ^ g[2] ^ g[3];
            if (BPW == 5 && g[BPW-1] != x) begin
               m_chk = 1'b1;
            end else begin
               exp_w.push_back({4'(k), g[0], g[1], g[2], g[3]});
               k++;
               if (m_wacc != 4'hF) m_wacc++;
            end
            g.delete();
         end
      end
   endtask

   task automatic compare(input string tag);
      check({tag, "_txn"}, 64'(got_tx.size()), 64'(exp_tx.size()));
      for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
         check({tag, "_tx"}, 64'(got_tx[i]), 64'(exp_tx[i]));
      check({tag, "_wn"}, 64'(got_w.size()), 64'(exp_w.size()));
      for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
         check({tag, "_w"}, 64'(got_w[i]), 64'(exp_w[i]));
      check({tag, "_status"}, 64'(status), 64'(m_status()));
      check({tag, "_idle"}, 64'(word_valid), 64'd0);
      exp_tx.delete();
      got_tx.delete();
      exp_w.delete();
      got_w.delete();
   endtask

   task automatic full_frame(input logic [7:0] cmd, input string tag);
      start_frame();
      send(cmd);
      foreach (stim[i]) send(stim[i]);
      end_frame();
      model_frame(cmd);
      compare(tag);
      stim.delete();
   endtask

   initial begin
      int r;
      int n;
      logic [7:0] cmd;
      tick(3);
      check("rst_valid", 64'(word_valid), 64'd0);
      check("rst_txload", 64'(tx_load), 64'd0);
      check("rst_txbyte", 64'(tx_byte), 64'd0);
      check("rst_word", 64'(word_out), 64'd0);
      check("rst_addr", 64'(word_addr), 64'd0);
      check("rst_status", 64'(status), 64'd0);
      reset = 1'b0;
      tick(2);

      stim = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      if (BPW == 5) stim.push_back(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
      full_frame(8'hAA, "basic");
      check("basic_acc", 64'(status[3:0]), 64'd1);

      gen_words(2);
      stim.push_back(8'h5A);
      stim.push_back(8'hA5);
      word_ready = 1'b0;
      exp_tx.push_back(m_status());
      exp_tx.push_back(8'hAA);
      for (int i = 0; i < 2 * BPW; i++) exp_tx.push_back(stim[i]);
      exp_w.push_back({4'd0, stim[0], stim[1], stim[2], stim[3]});
      m_ovr = 1'b1;
      start_frame();
      send(8'hAA);
      foreach (stim[i]) send(stim[i]);
      check("ovr_valid", 64'(word_valid), 64'd1);
      check("ovr_word", 64'({word_addr, word_out}), 64'(exp_w[0]));
      check("ovr_status", 64'(status), 64'(m_status()));
      end_frame();
      word_ready = 1'b1;
      tick(3);
      if (m_wacc != 4'hF) m_wacc++;
      compare("ovr");
      stim.delete();

      full_frame(8'h12, "badcmd");
      gen_words(1);
      full_frame(8'hAB, "clr");

      stim = '{8'h77, 8'h88};
      full_frame(8'hAA, "partial");
      gen_words(1);
      full_frame(8'hAA, "after_partial");

      gen_words(MAXW + 1);
      full_frame(8'hAB, "full");

`ifdef SPI_ASM_CHECKSUM_EN
      stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      full_frame(8'hAB, "ck_bad");
      stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
      full_frame(8'hAA, "ck_good");
`endif

      for (int f = 0; f < 12; f++) begin
         r = $urandom_range(0, 9);
         if (r < 6) cmd = 8'hAA;
         else if (r < 8) cmd = 8'hAB;
         else cmd = 8'($urandom);
         n = $urandom_range(0, BPW * (MAXW + 1));
         gen_words(MAXW + 1);
         while (stim.size() > n) void'(stim.pop_back());
         full_frame(cmd, "rnd");
      end

      start_frame();
      send(8'hAA);
      send(8'h01);
      send(8'h02);
      reset = 1'b1;
      tick(2);
      check("midrst_status", 64'(status), 64'd0);
      check("midrst_valid", 64'(word_valid), 64'd0);
      check("midrst_txload", 64'(tx_load), 64'd0);
      check("midrst_txbyte", 64'(tx_byte), 64'd0);
      check("midrst_word", 64'({word_addr, word_out}), 64'd0);
      reset = 1'b0;
      tick(2);
      got_tx.delete();
      send(8'hAA);
      send(8'h33);
      check("midrst_no_tx", 64'(got_tx.size()), 64'd0);
      cs_n = 1'b1;
      tick(4);
      m_ovr = 1'b0;
      m_chk = 1'b0;
      m_ferr = 1'b0;
      m_wacc = 4'd0;
      exp_tx.delete();
      got_tx.delete();
      exp_w.delete();
      got_w.delete();
      gen_words(2);
      full_frame(8'hAA, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
